rr_arbiter_casez: RTL
=====================

// Module: rr_arbiter_casez
// PURPOSE
//  Round-robin arbiter sharing one resource among N requesters. Winner is chosen
//  by a lowest-set-bit priority encoder applied first to requests at/above a
//  rotating pointer, then to all requests. Grant is registered and held until
//  release or hold-limit expiry, so no requester can starve the others.
// PARAMETERS
//  N         8  number of requesters (power of 2, >= 2)
//  MAX_HOLD  4  max consecutive cycles one grant may be held (>= 1)
// PORTS
//  clk        in   1           clock, all state updates on rising edge
//  areset_n   in   1           async reset, active-low
//  req        in   N           request vector, bit i = requester i
//  gnt        out  N           one-hot grant, registered
//  gnt_idx    out  $clog2(N)   index of granted requester, registered
//  gnt_valid  out  1           high while any grant held (== |gnt)
// BEHAVIOUR
//  - Reset: one clock, async active-low. areset_n=0 forces immediately:
//    gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, hold_cnt=0, state=IDLE.
//  - States: IDLE, GRANT.
//  - IDLE: if req==0 stay IDLE, outputs 0. Else on the edge:
//    masked = req & ~((1<<ptr)-1) (bits >= ptr); win = lsb(masked) if masked!=0
//    else lsb(req); gnt=1<<win, gnt_idx=win, gnt_valid=1, hold_cnt=0 -> GRANT.
//    Latency: req sampled at edge k -> gnt visible after edge k.
//  - GRANT: release on the edge when req[gnt_idx]==0 OR hold_cnt==MAX_HOLD-1;
//    on release gnt=0, gnt_valid=0, ptr=(gnt_idx+1) mod N (wraps N-1 -> 0),
//    -> IDLE. Otherwise hold_cnt++ and grant unchanged.
//  - Max grant length MAX_HOLD cycles; MAX_HOLD=1 gives single-cycle grants.
//  - One bubble cycle (IDLE) between consecutive grants; arbitration happens there.
//  - No preemption: other req bits changing during GRANT have no effect.
//  - Requester dropping req mid-grant: grant removed after the next edge.
//  - gnt_idx holds its last value in IDLE? No: gnt_idx returns to 0 on release.
//  - ptr updates only on release; unchanged in IDLE with req==0.
//  - Outputs always one-hot or zero; gnt_valid==|gnt at every cycle.
// STRUCTURE
//  - Package arb_pkg: state enum {IDLE, GRANT}, localparam IDX_W=$clog2(N).
//  - Sub-module lsb_prio_enc #(N): combinational casez lowest-set-bit encoder,
//    in[N-1:0] -> pos[IDX_W-1:0], any; pos=0 when in==0. Instantiated twice
//    (masked and unmasked request vectors).
//  - Top: state reg, ptr reg, hold_cnt reg ($clog2(MAX_HOLD+1) bits), output regs.
// TESTING (N=8, MAX_HOLD=4)
//  1. areset_n=0 mid-run -> gnt=8'h00, gnt_idx=0, gnt_valid=0 without clock edge;
//     after release, req=8'h80 -> gnt=8'h80, gnt_idx=7 (ptr reset to 0).
//  2. req=8'h01 for 2 cycles then 0 -> gnt=8'h01 for exactly 2 cycles, then 0;
//     next req=8'h03 -> gnt_idx=1 (ptr=1).
//  3. req=8'hFF held -> gnt_idx sequence 0,1,2,...,7,0; each grant 4 cycles,
//     one idle cycle between; ptr wraps 7->0.
//  4. ptr=6, req=8'h21 -> masked=0, falls back -> gnt=8'h01, gnt_idx=0.
//  5. ptr=3, req=8'h18 -> gnt=8'h08, gnt_idx=3; toggling req[4] during grant
//     does not change gnt.
//  6. Assertions every cycle: $onehot0(gnt), gnt_valid==|gnt, gnt[gnt_idx] when
//     valid, no grant longer than MAX_HOLD cycles, every held request granted
//     within N*(MAX_HOLD+1) cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizing for the round-robin arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned N_DEF    = 8;
  localparam int unsigned HOLD_DEF = 4;
  localparam int unsigned IDX_W    = $clog2(N_DEF);

endpackage

// File: rtl/rr_arbiter_casez_lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder; pos_o is 0 when nothing is set.
module lsb_prio_enc #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] in_i,
  output logic [W-1:0] pos_o,
  output logic         any_o
);

  assign any_o = |in_i;

  if (N == 8) begin : g_n8
    // Explicit wildcard table for the common 8-requester build
    always_comb begin
      pos_o = '0;
      casez (in_i)
        8'b???????1: pos_o = W'(0);
        8'b??????10: pos_o = W'(1);
        8'b?????100: pos_o = W'(2);
        8'b????1000: pos_o = W'(3);
        8'b???10000: pos_o = W'(4);
        8'b??100000: pos_o = W'(5);
        8'b?1000000: pos_o = W'(6);
        8'b10000000: pos_o = W'(7);
        default:     pos_o = '0;
      endcase
    end
  end else begin : g_generic
    // Scan from the top down so the lowest set bit wins
    always_comb begin
      pos_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (in_i[i]) pos_o = W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_casez.sv
// Round-robin arbiter: registered one-hot grant with hold limit and a rotating pointer.
module rr_arbiter_casez
  import arb_pkg::*;
#(
  parameter  int unsigned N        = N_DEF,
  parameter  int unsigned MAX_HOLD = HOLD_DEF,
  localparam int unsigned SEL_W    = $clog2(N),
  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [SEL_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;

  logic [N-1:0]      low_mask;
  logic [N-1:0]      masked_req;
  logic [SEL_W-1:0]  m_pos, u_pos, win;
  logic              m_any, u_any;

  // Requests at or above the pointer get first chance
  assign low_mask   = (N'(1) << ptr_q) - N'(1);
  assign masked_req = req & ~low_mask;

  lsb_prio_enc #(.N(N)) u_enc_masked (
    .in_i  (masked_req),
    .pos_o (m_pos),
    .any_o (m_any)
  );

  lsb_prio_enc #(.N(N)) u_enc_all (
    .in_i  (req),
    .pos_o (u_pos),
    .any_o (u_any)
  );

  assign win = m_any ? m_pos : u_pos;

  // State and output registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold or release in GRANT
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      IDLE: begin
        if (u_any) begin
          gnt_d       = N'(1) << win;
          gnt_idx_d   = win;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_W'(MAX_HOLD - 1))) begin
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          ptr_d       = gnt_idx_q + SEL_W'(1);
          state_d     = IDLE;
        end else begin
          hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule
